// File: rtl/mcaster_bus_resp.sv
// mcaster_bus_resp
//   Column-side responder on the X-bus. It filters broadcast ifmap/fltr/psum
//   beats by destination ID against a locally captured tag. It holds one kernel
//   of weights, streams matched beats to its PE, and returns PE results to the
//   bus.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   tag_in, flush_tag  local tag and the pulse that captures it
//   flush_kernel       pulse that captures kernel_size (nonzero) and starts a
//   kernel_size        weight load
//   ID, bus_valid      bus beat destination (MSB=1 is broadcast) and its valid
//   *_data_B2M         bus beat payload
//   tag_busy           high for the cycle after a tag capture
//   kernel_busy        high while weights are being loaded
//   *_data_M2P, READY  beat to the PE, with a one-cycle valid pulse
//   PE_EN              PE enable, high while streaming
//   pe_kernel_size     active kernel size
//   PE_VALID, *_P2M    PE result and its valid
//   *_data_M2B, VALID  PE result registered back to the bus
module mcaster_bus_resp #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_COL    = 4,
  parameter  int MAX_K      = 16,
  localparam int IDW        = $clog2(NUM_COL) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDW-1:0]            tag_in,
  input  logic [IDW-1:0]            ID,
  input  logic                      bus_valid,
  input  logic                      flush_tag,
  input  logic                      flush_kernel,
  input  logic [7:0]                kernel_size,
  input  logic [DATA_WIDTH-1:0]     ifmap_data_B2M,
  input  logic [DATA_WIDTH-1:0]     fltr_data_B2M,
  input  logic [2*DATA_WIDTH-1:0]   psum_data_B2M,
  output logic                      tag_busy,
  output logic                      kernel_busy,
  output logic                      VALID,
  output logic [DATA_WIDTH-1:0]     ifmap_data_M2B,
  output logic [DATA_WIDTH-1:0]     fltr_data_M2B,
  output logic [2*DATA_WIDTH-1:0]   psum_data_M2B,
  output logic [DATA_WIDTH-1:0]     ifmap_data_M2P,
  output logic [DATA_WIDTH-1:0]     fltr_data_M2P,
  output logic [2*DATA_WIDTH-1:0]   psum_data_M2P,
  output logic                      PE_EN,
  output logic                      READY,
  output logic [7:0]                pe_kernel_size,
  input  logic                      PE_VALID,
  input  logic [DATA_WIDTH-1:0]     ifmap_data_P2M,
  input  logic [DATA_WIDTH-1:0]     fltr_data_P2M,
  input  logic [2*DATA_WIDTH-1:0]   psum_data_P2M
);

  localparam int         IXW   = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam logic [7:0] MAXK8 = 8'(MAX_K);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KLOAD  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDW-1:0]            tag_q, tag_d;
  logic [7:0]                ksize_q, ksize_d;
  logic [IXW-1:0]            idx_q, idx_d;
  logic                      tag_busy_q, tag_busy_d;
  logic                      ready_q, ready_d;
  logic [DATA_WIDTH-1:0]     ifmap_m2p_q, ifmap_m2p_d;
  logic [DATA_WIDTH-1:0]     fltr_m2p_q, fltr_m2p_d;
  logic [2*DATA_WIDTH-1:0]   psum_m2p_q, psum_m2p_d;
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     ifmap_m2b_q, ifmap_m2b_d;
  logic [DATA_WIDTH-1:0]     fltr_m2b_q, fltr_m2b_d;
  logic [2*DATA_WIDTH-1:0]   psum_m2b_q, psum_m2b_d;

  logic [DATA_WIDTH-1:0]     w_q [MAX_K];
  logic                      w_we;

  logic                      match;
  logic                      idx_last;

  // Matching uses the registered tag, so a tag captured this cycle only
  // affects beats from the next cycle on.
  assign match    = bus_valid & (ID[IDW-1] | (ID == tag_q));
  assign idx_last = (8'(idx_q) == (ksize_q - 8'd1));

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    ksize_d     = ksize_q;
    idx_d       = idx_q;
    tag_busy_d  = 1'b0;
    ready_d     = 1'b0;
    ifmap_m2p_d = ifmap_m2p_q;
    fltr_m2p_d  = fltr_m2p_q;
    psum_m2p_d  = psum_m2p_q;
    valid_d     = 1'b0;
    ifmap_m2b_d = ifmap_m2b_q;
    fltr_m2b_d  = fltr_m2b_q;
    psum_m2b_d  = psum_m2b_q;
    w_we        = 1'b0;

    if (flush_tag) begin
      tag_d      = tag_in;
      tag_busy_d = 1'b1;
    end

    // A kernel flush restarts loading from any state; a beat in the same
    // cycle is dropped because the buffer is being re-armed.
    if (flush_kernel && (kernel_size != '0)) begin
      state_d = KLOAD;
      idx_d   = '0;
      ksize_d = (kernel_size > MAXK8) ? MAXK8 : kernel_size;
    end else begin
      unique case (state_q)
        KLOAD: begin
          if (match) begin
            w_we = 1'b1;
            if (idx_last) begin
              state_d = STREAM;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IXW'(1);
            end
          end
        end
        STREAM: begin
          if (match) begin
            ready_d     = 1'b1;
            ifmap_m2p_d = ifmap_data_B2M;
            psum_m2p_d  = psum_data_B2M;
            fltr_m2p_d  = w_q[idx_q];
            idx_d       = idx_last ? '0 : idx_q + IXW'(1);
          end
        end
        default: ;
      endcase
    end

    if (PE_VALID) begin
      valid_d     = 1'b1;
      ifmap_m2b_d = ifmap_data_P2M;
      fltr_m2b_d  = fltr_data_P2M;
      psum_m2b_d  = psum_data_P2M;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      ksize_q     <= '0;
      idx_q       <= '0;
      tag_busy_q  <= 1'b0;
      ready_q     <= 1'b0;
      ifmap_m2p_q <= '0;
      fltr_m2p_q  <= '0;
      psum_m2p_q  <= '0;
      valid_q     <= 1'b0;
      ifmap_m2b_q <= '0;
      fltr_m2b_q  <= '0;
      psum_m2b_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      ksize_q     <= ksize_d;
      idx_q       <= idx_d;
      tag_busy_q  <= tag_busy_d;
      ready_q     <= ready_d;
      ifmap_m2p_q <= ifmap_m2p_d;
      fltr_m2p_q  <= fltr_m2p_d;
      psum_m2p_q  <= psum_m2p_d;
      valid_q     <= valid_d;
      ifmap_m2b_q <= ifmap_m2b_d;
      fltr_m2b_q  <= fltr_m2b_d;
      psum_m2b_q  <= psum_m2b_d;
    end
  end

  // Weight storage is plain memory; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (!rst && w_we) begin
      w_q[idx_q] <= fltr_data_B2M;
    end
  end

  assign tag_busy       = tag_busy_q;
  assign kernel_busy    = (state_q == KLOAD);
  assign PE_EN          = (state_q == STREAM);
  assign pe_kernel_size = ksize_q;
  assign READY          = ready_q;
  assign ifmap_data_M2P = ifmap_m2p_q;
  assign fltr_data_M2P  = fltr_m2p_q;
  assign psum_data_M2P  = psum_m2p_q;
  assign VALID          = valid_q;
  assign ifmap_data_M2B = ifmap_m2b_q;
  assign fltr_data_M2B  = fltr_m2b_q;
  assign psum_data_M2B  = psum_m2b_q;

endmodule

// File: tb/tb_mcaster_bus_resp.sv
// Directed bench for mcaster_bus_resp (NUM_COL=8, so IDs are 4 bits and
// 4'b1000 is broadcast).
module tb_mcaster_bus_resp;

  localparam int DW  = 16;
  localparam int IDW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [IDW-1:0]  tag_in, ID;
  logic            bus_valid, flush_tag, flush_kernel;
  logic [7:0]      kernel_size;
  logic [DW-1:0]   ifmap_data_B2M, fltr_data_B2M;
  logic [2*DW-1:0] psum_data_B2M;
  logic            tag_busy, kernel_busy, VALID, PE_EN, READY;
  logic [DW-1:0]   ifmap_data_M2B, fltr_data_M2B, ifmap_data_M2P, fltr_data_M2P;
  logic [2*DW-1:0] psum_data_M2B, psum_data_M2P;
  logic [7:0]      pe_kernel_size;
  logic            PE_VALID;
  logic [DW-1:0]   ifmap_data_P2M, fltr_data_P2M;
  logic [2*DW-1:0] psum_data_P2M;

  int n_tests = 0;
  int n_fail  = 0;

  mcaster_bus_resp #(.DATA_WIDTH(DW), .NUM_COL(8), .MAX_K(16)) dut (
    .clk(clk), .rst(rst), .tag_in(tag_in), .ID(ID), .bus_valid(bus_valid),
    .flush_tag(flush_tag), .flush_kernel(flush_kernel), .kernel_size(kernel_size),
    .ifmap_data_B2M(ifmap_data_B2M), .fltr_data_B2M(fltr_data_B2M),
    .psum_data_B2M(psum_data_B2M), .tag_busy(tag_busy), .kernel_busy(kernel_busy),
    .VALID(VALID), .ifmap_data_M2B(ifmap_data_M2B), .fltr_data_M2B(fltr_data_M2B),
    .psum_data_M2B(psum_data_M2B), .ifmap_data_M2P(ifmap_data_M2P),
    .fltr_data_M2P(fltr_data_M2P), .psum_data_M2P(psum_data_M2P), .PE_EN(PE_EN),
    .READY(READY), .pe_kernel_size(pe_kernel_size), .PE_VALID(PE_VALID),
    .ifmap_data_P2M(ifmap_data_P2M), .fltr_data_P2M(fltr_data_P2M),
    .psum_data_P2M(psum_data_P2M)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_tag = 1'b0; flush_kernel = 1'b0; bus_valid = 1'b0; PE_VALID = 1'b0;
  endtask

  task automatic beat(input logic [IDW-1:0] id, input logic [DW-1:0] ifm,
                      input logic [DW-1:0] flt, input logic [2*DW-1:0] ps);
    bus_valid = 1'b1; ID = id; ifmap_data_B2M = ifm; fltr_data_B2M = flt; psum_data_B2M = ps;
  endtask

  logic [DW-1:0] exp_w [4];

  initial begin
    rst = 1'b1; tag_in = '0; ID = '0; kernel_size = '0;
    ifmap_data_B2M = '0; fltr_data_B2M = '0; psum_data_B2M = '0;
    ifmap_data_P2M = '0; fltr_data_P2M = '0; psum_data_P2M = '0;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    check_eq("rst_tag_busy", 32'(tag_busy), 0);
    check_eq("rst_kbusy", 32'(kernel_busy), 0);
    check_eq("rst_pe_en", 32'(PE_EN), 0);
    check_eq("rst_ready", 32'(READY), 0);
    check_eq("rst_valid", 32'(VALID), 0);
    check_eq("rst_ksize", 32'(pe_kernel_size), 0);

    // Tag capture: busy exactly one cycle.
    flush_tag = 1'b1; tag_in = 4'd2;
    step(); flush_tag = 1'b0;
    check_eq("tag_busy_hi", 32'(tag_busy), 1);
    step();
    check_eq("tag_busy_lo", 32'(tag_busy), 0);

    // Kernel load of 3 taps.
    flush_kernel = 1'b1; kernel_size = 8'd3;
    step(); flush_kernel = 1'b0;
    check_eq("kbusy_start", 32'(kernel_busy), 1);
    check_eq("ksize_3", 32'(pe_kernel_size), 3);
    for (int i = 0; i < 3; i++) begin
      beat(4'd2, '0, 16'(5 + i), '0);
      step();
      check_eq("kbusy_load", 32'(kernel_busy), (i < 2) ? 32'd1 : 32'd0);
    end
    bus_valid = 1'b0;
    check_eq("pe_en_stream", 32'(PE_EN), 1);

    // Streaming with weight wrap.
    exp_w[0] = 16'd5; exp_w[1] = 16'd6; exp_w[2] = 16'd7; exp_w[3] = 16'd5;
    for (int i = 0; i < 4; i++) begin
      beat(4'd2, 16'(i + 1), 16'hFFFF, 32'(100 + i));
      step();
      check_eq("stream_ready", 32'(READY), 1);
      check_eq("stream_ifmap", 32'(ifmap_data_M2P), 32'(i + 1));
      check_eq("stream_fltr", 32'(fltr_data_M2P), 32'(exp_w[i]));
      check_eq("stream_psum", psum_data_M2P, 32'(100 + i));
    end
    bus_valid = 1'b0;
    step();
    check_eq("ready_pulse", 32'(READY), 0);

    // Filtering: ID=1 dropped, broadcast forwarded with next weight (w[1]).
    beat(4'd1, 16'd8, '0, '0);
    step();
    check_eq("id1_drop", 32'(READY), 0);
    beat(4'b1000, 16'd9, '0, '0);
    step();
    check_eq("bcast_ready", 32'(READY), 1);
    check_eq("bcast_ifmap", 32'(ifmap_data_M2P), 9);
    check_eq("bcast_fltr", 32'(fltr_data_M2P), 6);

    // New tag does not apply to a beat in the capture cycle.
    flush_tag = 1'b1; tag_in = 4'd3;
    beat(4'd3, 16'd10, '0, '0);
    step(); flush_tag = 1'b0;
    check_eq("tag_same_cyc", 32'(READY), 0);
    beat(4'd3, 16'd11, '0, '0);
    step();
    check_eq("tag_new_ready", 32'(READY), 1);
    check_eq("tag_new_fltr", 32'(fltr_data_M2P), 7);
    beat(4'd2, 16'd12, '0, '0);
    step();
    check_eq("old_tag_drop", 32'(READY), 0);
    bus_valid = 1'b0;

    // Return path.
    PE_VALID = 1'b1; psum_data_P2M = 32'h1234; ifmap_data_P2M = 16'h55; fltr_data_P2M = 16'h66;
    step(); PE_VALID = 1'b0; psum_data_P2M = 32'hDEAD;
    check_eq("ret_valid", 32'(VALID), 1);
    check_eq("ret_psum", psum_data_M2B, 32'h1234);
    check_eq("ret_ifmap", 32'(ifmap_data_M2B), 32'h55);
    check_eq("ret_fltr", 32'(fltr_data_M2B), 32'h66);
    step();
    check_eq("ret_valid_lo", 32'(VALID), 0);
    check_eq("ret_psum_hold", psum_data_M2B, 32'h1234);

    // kernel_size=0 ignored.
    flush_kernel = 1'b1; kernel_size = 8'd0;
    step(); flush_kernel = 1'b0;
    check_eq("k0_pe_en", 32'(PE_EN), 1);
    check_eq("k0_kbusy", 32'(kernel_busy), 0);
    check_eq("k0_ksize", 32'(pe_kernel_size), 3);

    // Mid-stream flush with clamp 40 -> 16.
    flush_kernel = 1'b1; kernel_size = 8'd40;
    step(); flush_kernel = 1'b0;
    check_eq("abort_pe_en", 32'(PE_EN), 0);
    check_eq("abort_kbusy", 32'(kernel_busy), 1);
    check_eq("clamp_ksize", 32'(pe_kernel_size), 16);
    for (int i = 0; i < 16; i++) begin
      beat(4'd3, '0, 16'(200 + i), '0);
      step();
      if (i == 14) check_eq("k16_busy_14", 32'(kernel_busy), 1);
    end
    check_eq("k16_done", 32'(kernel_busy), 0);
    check_eq("k16_pe_en", 32'(PE_EN), 1);
    beat(4'd3, 16'd1, '0, '0);
    step();
    check_eq("k16_fltr0", 32'(fltr_data_M2P), 200);

    // Reset mid-stream discards the in-flight beat.
    beat(4'd3, 16'd2, '0, '0);
    rst = 1'b1;
    step(); rst = 1'b0; bus_valid = 1'b0;
    check_eq("rst_mid_ready", 32'(READY), 0);
    check_eq("rst_mid_pe_en", 32'(PE_EN), 0);
    check_eq("rst_mid_ksize", 32'(pe_kernel_size), 0);
    check_eq("rst_mid_m2p", 32'(ifmap_data_M2P), 0);

    // Tag is 0 again; beat in IDLE is dropped.
    beat(4'd0, 16'd3, '0, '0);
    step(); bus_valid = 1'b0;
    check_eq("idle_drop", 32'(READY), 0);

    // Simultaneous tag and kernel flush.
    flush_tag = 1'b1; tag_in = 4'd5; flush_kernel = 1'b1; kernel_size = 8'd2;
    step(); idle_inputs();
    check_eq("both_tag_busy", 32'(tag_busy), 1);
    check_eq("both_kbusy", 32'(kernel_busy), 1);
    check_eq("both_ksize", 32'(pe_kernel_size), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
